coin_change_dispenser: RTL and testbench

COIN_CHANGE_DISPENSER -- requirements
Module: coin_change_dispenser

---
 rtl/coin_change_dispenser_pkg.sv | 50 +++++
 rtl/coin_change_dispenser_tube.sv | 34 +++
 rtl/coin_change_dispenser.sv | 177 +++++++++++++++++
 tb/tb_coin_change_dispenser.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coin_change_dispenser_pkg.sv
// rtl/coin_change_dispenser_pkg.sv - shared vending definitions: money width, coin codes/values, FSM encodings
package coin_change_dispenser_pkg;

   // Money is counted in cents on an 8-bit unsigned datapath
   localparam int MONEY_W = 8;
   typedef logic [MONEY_W-1:0] money_t;

   // One-hot coin codes, bit order shared by coin_type and the empty flags
   localparam int COIN_W = 3;
   typedef logic [COIN_W-1:0] coin_t;

   localparam coin_t COIN_NONE    = 3'b000;
   localparam coin_t COIN_NICKEL  = 3'b001;
   localparam coin_t COIN_DIME    = 3'b010;
   localparam coin_t COIN_QUARTER = 3'b100;

   localparam money_t VAL_NICKEL  = 8'd5;
   localparam money_t VAL_DIME    = 8'd10;
   localparam money_t VAL_QUARTER = 8'd25;

   // Tube occupancy width, enough for a full tube of 15 coins
   localparam int TUBE_W = 4;
   typedef logic [TUBE_W-1:0] tube_cnt_t;

   // Dispenser FSM encodings
   localparam int ST_W = 3;
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SELECT  = 3'd1;
   localparam logic [2:0] ST_PRESENT = 3'd2;
   localparam logic [2:0] ST_DONE    = 3'd3;
   localparam logic [2:0] ST_FAIL    = 3'd4;

   // Cent value of a one-hot coin code; anything else is worth nothing
   function automatic money_t coin_value(input coin_t c);
      money_t v;
      case (c)
         COIN_NICKEL:  v = VAL_NICKEL;
         COIN_DIME:    v = VAL_DIME;
         COIN_QUARTER: v = VAL_QUARTER;
         default:      v = '0;
      endcase
      return v;
   endfunction

   // Only amounts that are whole nickels can ever be paid out exactly
   function automatic logic is_payable(input money_t m);
      return (m % VAL_NICKEL) == 8'd0;
   endfunction

endpackage

// File: rtl/coin_change_dispenser_tube.sv
// rtl/coin_change_dispenser_tube.sv - one coin tube: load to full, decrement on eject, count and empty flag
module coin_tube_counter
   import coin_change_dispenser_pkg::*;
#(
   parameter int STOCK_MAX = 15
) (
   input  logic      i_clk,
   input  logic      i_clr,
   input  logic      i_load,
   input  logic      i_dec,
   output tube_cnt_t o_count,
   output logic      o_empty
);

   localparam tube_cnt_t FULL = tube_cnt_t'(STOCK_MAX);

   tube_cnt_t r_count;
   logic      r_empty;

   // Count and empty flag move together so empty is never a cycle late
   always_ff @(posedge i_clk) begin
      if (i_clr || i_load) begin
         r_count <= FULL;
         r_empty <= (FULL == '0);
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - tube_cnt_t'(1);
         r_empty <= (r_count == tube_cnt_t'(1));
      end
   end

   assign o_count = r_count;
   assign o_empty = r_empty;

endmodule

// File: rtl/coin_change_dispenser.sv
// rtl/coin_change_dispenser.sv - greedy change payout FSM over three coin tubes
module coin_change_dispenser
   import coin_change_dispenser_pkg::*;
#(
   parameter int STOCK_MAX = 15
) (
   input  logic               i_clk,
   input  logic               i_clr,
   input  logic               i_start,
   input  logic [MONEY_W-1:0] i_change_amount,
   input  logic               i_restock,
   input  logic               i_coin_ack,
   output logic               o_coin_valid,
   output logic [COIN_W-1:0]  o_coin_type,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_err,
   output logic [MONEY_W-1:0] o_remaining,
   output logic [COIN_W-1:0]  o_empty
);

   logic [ST_W-1:0] r_state;
   money_t          r_remaining;
   logic            r_coin_valid;
   coin_t           r_coin_type;
   logic            r_busy;
   logic            r_done;
   logic            r_err;

   tube_cnt_t w_cnt_n;
   tube_cnt_t w_cnt_d;
   tube_cnt_t w_cnt_q;
   logic      w_empty_n;
   logic      w_empty_d;
   logic      w_empty_q;
   logic      w_load;
   logic      w_eject;
   logic      w_dec_n;
   logic      w_dec_d;
   logic      w_dec_q;
   coin_t     w_pick;
   money_t    w_coin_val;

   // Refill is only honoured between requests; a coin leaves its tube on the acked PRESENT cycle
   assign w_load     = (r_state == ST_IDLE) && i_restock;
   assign w_eject    = (r_state == ST_PRESENT) && i_coin_ack;
   assign w_dec_n    = w_eject && r_coin_type[0];
   assign w_dec_d    = w_eject && r_coin_type[1];
   assign w_dec_q    = w_eject && r_coin_type[2];
   assign w_coin_val = coin_value(r_coin_type);

   coin_tube_counter #(.STOCK_MAX(STOCK_MAX)) u_tube_nickel (
      .i_clk   (i_clk),
      .i_clr   (i_clr),
      .i_load  (w_load),
      .i_dec   (w_dec_n),
      .o_count (w_cnt_n),
      .o_empty (w_empty_n)
   );

   coin_tube_counter #(.STOCK_MAX(STOCK_MAX)) u_tube_dime (
      .i_clk   (i_clk),
      .i_clr   (i_clr),
      .i_load  (w_load),
      .i_dec   (w_dec_d),
      .o_count (w_cnt_d),
      .o_empty (w_empty_d)
   );

   coin_tube_counter #(.STOCK_MAX(STOCK_MAX)) u_tube_quarter (
      .i_clk   (i_clk),
      .i_clr   (i_clr),
      .i_load  (w_load),
      .i_dec   (w_dec_q),
      .o_count (w_cnt_q),
      .o_empty (w_empty_q)
   );

   // Greedy choice: largest coin that fits in what is owed and is still in stock
   always_comb begin
      w_pick = COIN_NONE;
      if ((r_remaining >= VAL_QUARTER) && (w_cnt_q != '0)) begin
         w_pick = COIN_QUARTER;
      end else if ((r_remaining >= VAL_DIME) && (w_cnt_d != '0)) begin
         w_pick = COIN_DIME;
      end else if ((r_remaining >= VAL_NICKEL) && (w_cnt_n != '0)) begin
         w_pick = COIN_NICKEL;
      end
   end

   // Request sequencing: accept, pick, present until acked, then finish or fail
   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_state      <= ST_IDLE;
         r_remaining  <= '0;
         r_coin_valid <= 1'b0;
         r_coin_type  <= COIN_NONE;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_remaining <= i_change_amount;
                  r_busy      <= 1'b1;
                  r_state     <= is_payable(i_change_amount) ? ST_SELECT : ST_FAIL;
               end
            end

            ST_SELECT: begin
               if (w_pick != COIN_NONE) begin
                  r_coin_valid <= 1'b1;
                  r_coin_type  <= w_pick;
                  r_state      <= ST_PRESENT;
               end else if (r_remaining == '0) begin
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_done  <= 1'b1;
                  r_err   <= 1'b1;
                  r_state <= ST_FAIL;
               end
            end

            ST_PRESENT: begin
               if (i_coin_ack) begin
                  if (r_remaining >= w_coin_val) begin
                     r_remaining <= r_remaining - w_coin_val;
                  end
                  r_coin_valid <= 1'b0;
                  r_coin_type  <= COIN_NONE;
                  r_state      <= ST_SELECT;
               end
            end

            ST_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end

            ST_FAIL: begin
               // An unpayable amount arrives here straight from IDLE without its pulse,
               // so FAIL shows the pulse first and only then returns to IDLE
               if (!r_err) begin
                  r_done <= 1'b1;
                  r_err  <= 1'b1;
               end else begin
                  r_done  <= 1'b0;
                  r_err   <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end

            default: begin
               r_coin_valid <= 1'b0;
               r_coin_type  <= COIN_NONE;
               r_done       <= 1'b0;
               r_err        <= 1'b0;
               r_busy       <= 1'b0;
               r_state      <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_coin_valid = r_coin_valid;
   assign o_coin_type  = r_coin_type;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_err        = r_err;
   assign o_remaining  = r_remaining;
   assign o_empty      = {w_empty_q, w_empty_d, w_empty_n};

endmodule

// File: tb/tb_coin_change_dispenser.sv
// tb/tb_coin_change_dispenser.sv - self-checking bench for coin_change_dispenser
module tb_coin_change_dispenser;

   logic       clk = 1'b0;
   logic       clr, start, restock, coin_ack, sel;
   logic [7:0] amount;

   logic       a_valid, a_busy, a_done, a_err;
   logic [2:0] a_type, a_empty;
   logic [7:0] a_rem;
   logic       b_valid, b_busy, b_done, b_err;
   logic [2:0] b_type, b_empty;
   logic [7:0] b_rem;

   logic       c_valid, c_busy, c_done, c_err;
   logic [2:0] c_type, c_empty;
   logic [7:0] c_rem;

   int n_checks = 0;
   int n_errors = 0;

   logic [2:0] got_coins[$];
   logic [2:0] got_first;
   logic       got_err;
   logic [7:0] got_rem;

   int         m_stock[3];
   logic [2:0] m_coins[$];
   int         m_rem;
   logic       m_err;

   typedef struct {
      logic [7:0] amt;
      logic       rs;
      int         n;
      logic [2:0] first;
      logic       err;
      logic [7:0] rem;
      logic [2:0] empty;
   } vec_t;
   vec_t tbl[8];

   always #5 clk = ~clk;

   coin_change_dispenser dut (
      .i_clk           (clk),
      .i_clr           (clr),
      .i_start         (start & ~sel),
      .i_change_amount (amount),
      .i_restock       (restock & ~sel),
      .i_coin_ack      (coin_ack & ~sel),
      .o_coin_valid    (a_valid),
      .o_coin_type     (a_type),
      .o_busy          (a_busy),
      .o_done          (a_done),
      .o_err           (a_err),
      .o_remaining     (a_rem),
      .o_empty         (a_empty)
   );

   coin_change_dispenser #(.STOCK_MAX(1)) dut1 (
      .i_clk           (clk),
      .i_clr           (clr),
      .i_start         (start & sel),
      .i_change_amount (amount),
      .i_restock       (restock & sel),
      .i_coin_ack      (coin_ack & sel),
      .o_coin_valid    (b_valid),
      .o_coin_type     (b_type),
      .o_busy          (b_busy),
      .o_done          (b_done),
      .o_err           (b_err),
      .o_remaining     (b_rem),
      .o_empty         (b_empty)
   );

   assign c_valid = sel ? b_valid : a_valid;
   assign c_type  = sel ? b_type  : a_type;
   assign c_busy  = sel ? b_busy  : a_busy;
   assign c_done  = sel ? b_done  : a_done;
   assign c_err   = sel ? b_err   : a_err;
   assign c_rem   = sel ? b_rem   : a_rem;
   assign c_empty = sel ? b_empty : a_empty;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // Issue one request at a negedge, ack each coin after 0..max_delay idle cycles,
   // and record what was presented and how the request ended.
   task automatic run_req(input logic [7:0] amt, input logic rs, input int max_delay);
      int         cyc;
      int         d;
      logic [2:0] held;
      got_coins.delete();
      amount  = amt;
      start   = 1'b1;
      restock = rs;
      @(negedge clk);
      start   = 1'b0;
      restock = 1'b0;
      cyc = 0;
      while (!c_done && cyc < 3000) begin
         if (c_valid) begin
            held = c_type;
            got_coins.push_back(held);
            d = $urandom_range(max_delay, 0);
            for (int k = 0; k < d; k++) begin
               @(negedge clk);
               check("coin_stable", {28'd0, c_valid, c_type}, {28'd0, 1'b1, held});
            end
            coin_ack = 1'b1;
            @(negedge clk);
            coin_ack = 1'b0;
         end else begin
            @(negedge clk);
         end
         cyc++;
      end
      got_first = (got_coins.size() > 0) ? got_coins[0] : 3'b000;
      if (!c_done) begin
         check("req_timeout", 0, 1);
         got_err = 1'bx;
         got_rem = 8'hxx;
      end else begin
         got_err = c_err;
         got_rem = c_rem;
         @(negedge clk);
         check("pulse_end", {29'd0, c_done, c_err, c_busy}, 0);
      end
   endtask

   // Reference: pay the amount greedily from the tube stock, largest fitting coin first
   task automatic model_req(input int amt, input logic rs);
      int vals[3];
      int pick;
      vals = '{5, 10, 25};
      if (rs) for (int i = 0; i < 3; i++) m_stock[i] = 15;
      m_coins.delete();
      m_rem = amt;
      if (amt % 5 != 0) begin
         m_err = 1'b1;
         return;
      end
      while (m_rem > 0) begin
         pick = -1;
         for (int i = 2; i >= 0; i--)
            if (pick < 0 && m_rem >= vals[i] && m_stock[i] > 0) pick = i;
         if (pick < 0) break;
         m_stock[pick]--;
         m_rem -= vals[pick];
         m_coins.push_back(3'(1 << pick));
      end
      m_err = (m_rem != 0);
   endtask

   initial begin
      int         cyc;
      int         amt;
      logic       rs;
      logic [2:0] exp_empty;

      tbl[0] = '{8'd35,  1'b0, 2,  3'b100, 1'b0, 8'd0, 3'b000};
      tbl[1] = '{8'd0,   1'b0, 0,  3'b000, 1'b0, 8'd0, 3'b000};
      tbl[2] = '{8'd7,   1'b0, 0,  3'b000, 1'b1, 8'd7, 3'b000};
      tbl[3] = '{8'd40,  1'b0, 3,  3'b100, 1'b0, 8'd0, 3'b000};
      tbl[4] = '{8'd255, 1'b0, 11, 3'b100, 1'b0, 8'd0, 3'b000};
      tbl[5] = '{8'd100, 1'b0, 6,  3'b100, 1'b0, 8'd0, 3'b100};
      tbl[6] = '{8'd25,  1'b0, 3,  3'b010, 1'b0, 8'd0, 3'b100};
      tbl[7] = '{8'd30,  1'b1, 2,  3'b100, 1'b0, 8'd0, 3'b000};

      clr = 1'b1; start = 1'b0; restock = 1'b0; coin_ack = 1'b0; sel = 1'b0; amount = 8'd0;
      repeat (2) @(negedge clk);
      check("rst_outs", {a_valid, a_type, a_busy, a_done, a_err}, 0);
      check("rst_rem", a_rem, 0);
      check("rst_empty", a_empty, 0);
      check("rst_cnt", {dut.w_cnt_q, dut.w_cnt_d, dut.w_cnt_n}, 12'hfff);
      check("rst_empty1", b_empty, 0);
      clr = 1'b0;
      @(negedge clk);

      // zero amount: DONE two cycles after start, no error
      amount = 8'd0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      check("amt0_c1", {a_busy, a_done, a_err, a_valid}, 4'b1000);
      @(negedge clk);
      check("amt0_c2", {a_busy, a_done, a_err, a_valid}, 4'b1100);
      @(negedge clk);
      check("amt0_c3", {a_busy, a_done, a_err}, 3'b000);

      // unpayable amount: no coin, done+err two cycles after start
      amount = 8'd7; start = 1'b1;
      @(negedge clk); start = 1'b0;
      check("amt7_c1", {a_busy, a_done, a_err, a_valid}, 4'b1000);
      @(negedge clk);
      check("amt7_c2", {a_busy, a_done, a_err, a_valid}, 4'b1110);
      check("amt7_rem", a_rem, 7);
      @(negedge clk);
      check("amt7_c3", {a_busy, a_done, a_err, a_valid}, 4'b0000);

      for (int t = 0; t < 8; t++) begin
         run_req(tbl[t].amt, tbl[t].rs, t % 3);
         check($sformatf("tbl%0d_n", t), got_coins.size(), tbl[t].n);
         check($sformatf("tbl%0d_first", t), got_first, tbl[t].first);
         check($sformatf("tbl%0d_err", t), got_err, tbl[t].err);
         check($sformatf("tbl%0d_rem", t), got_rem, tbl[t].rem);
         check($sformatf("tbl%0d_empty", t), a_empty, tbl[t].empty);
         @(negedge clk);
         check($sformatf("tbl%0d_rem_hold", t), a_rem, tbl[t].rem);
         if (t == 0) check("tbl0_qd_cnt", {dut.w_cnt_q, dut.w_cnt_d}, 8'hee);
      end

      // stall in PRESENT for 100 cycles with stray start/restock pulses
      amount = 8'd20; start = 1'b1;
      @(negedge clk); start = 1'b0;
      cyc = 0;
      while (!a_valid && cyc < 20) begin @(negedge clk); cyc++; end
      check("hold_rise", {a_valid, a_type}, 4'b1010);
      for (int k = 0; k < 100; k++) begin
         start   = (k % 9 == 4);
         amount  = 8'd5;
         restock = (k % 7 == 3);
         @(negedge clk);
         check("hold_stable", {a_valid, a_type}, 4'b1010);
      end
      start = 1'b0; restock = 1'b0;
      cyc = 0;
      while (!a_done && cyc < 50) begin
         coin_ack = a_valid;
         @(negedge clk);
         cyc++;
      end
      coin_ack = 1'b0;
      check("hold_done", {a_done, a_err}, 2'b10);
      check("hold_rem", a_rem, 0);
      check("hold_cnt", {dut.w_cnt_q, dut.w_cnt_d, dut.w_cnt_n}, 12'hedE);
      repeat (2) @(negedge clk);

      // clear while a coin is being presented
      amount = 8'd35; start = 1'b1;
      @(negedge clk); start = 1'b0;
      cyc = 0;
      while (!a_valid && cyc < 20) begin @(negedge clk); cyc++; end
      check("clr_pre", a_valid, 1);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("clr_outs", {a_valid, a_type, a_busy, a_done, a_err}, 0);
      check("clr_rem", a_rem, 0);
      check("clr_cnt", {dut.w_cnt_q, dut.w_cnt_d, dut.w_cnt_n}, 12'hfff);
      @(negedge clk);

      // randomized requests against the greedy reference
      for (int i = 0; i < 3; i++) m_stock[i] = 15;
      for (int r = 0; r < 40; r++) begin
         rs  = ($urandom_range(3, 0) == 0);
         amt = ($urandom_range(3, 0) == 0) ? int'($urandom_range(255, 0)) : int'($urandom_range(51, 0)) * 5;
         model_req(amt, rs);
         run_req(8'(amt), rs, 3);
         check("rnd_n", got_coins.size(), m_coins.size());
         for (int k = 0; k < m_coins.size() && k < got_coins.size(); k++)
            check("rnd_coin", got_coins[k], m_coins[k]);
         check("rnd_err", got_err, m_err);
         check("rnd_rem", got_rem, m_rem);
         exp_empty = {m_stock[2] == 0, m_stock[1] == 0, m_stock[0] == 0};
         check("rnd_empty", a_empty, exp_empty);
      end

      // single-coin tubes run dry part way through 50 cents
      sel = 1'b1;
      @(negedge clk);
      run_req(8'd50, 1'b0, 0);
      check("s1_n", got_coins.size(), 3);
      if (got_coins.size() == 3) begin
         check("s1_c0", got_coins[0], 3'b100);
         check("s1_c1", got_coins[1], 3'b010);
         check("s1_c2", got_coins[2], 3'b001);
      end
      check("s1_err", got_err, 1);
      check("s1_rem", got_rem, 10);
      check("s1_empty", b_empty, 3'b111);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
